// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, state encoding and sample types for the FIR MAC stage.
// Build option FIR_MAC_SATURATE_EN selects output saturation instead of wrap.
package fir_pkg;

  localparam int DATA_WIDTH_D = 13;
  localparam int COEF_WIDTH_D = 13;
  localparam int TAPS_D       = 8;
  localparam int SHIFT_D      = 12;
  localparam int OUT_WIDTH_D  = 16;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_mac_state_t;

  typedef logic signed [DATA_WIDTH_D-1:0] sample_t;
  typedef logic signed [COEF_WIDTH_D-1:0] coef_t;

endpackage

// File: rtl/fir_mac_u_if.sv
// fir_mac_u_if: tap/coefficient inputs and filtered-sample outputs of fir_mac_u.
// master drives taps and coefficient writes; slave is the MAC stage.
interface fir_mac_u_if
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int COEF_WIDTH = COEF_WIDTH_D,
  parameter int TAPS       = TAPS_D,
  parameter int OUT_WIDTH  = OUT_WIDTH_D
) ();

  localparam int AW = $clog2(TAPS);

  logic                         VIN;
  logic signed [DATA_WIDTH-1:0] tp [0:TAPS-1];
  logic                         COEF_WE;
  logic [AW-1:0]                COEF_ADDR;
  logic signed [COEF_WIDTH-1:0] COEF_DIN;
  logic signed [OUT_WIDTH-1:0]  DOUT;
  logic                         VOUT;
  logic                         BUSY;
  logic                         OVR;

  modport master (
    output VIN, tp, COEF_WE, COEF_ADDR, COEF_DIN,
    input  DOUT, VOUT, BUSY, OVR
  );

  modport slave (
    input  VIN, tp, COEF_WE, COEF_ADDR, COEF_DIN,
    output DOUT, VOUT, BUSY, OVR
  );

endinterface

// File: rtl/fir_out_scale.sv
// fir_out_scale: arithmetic right shift of the accumulator, then narrowing.
// FIR_MAC_SATURATE_EN defined -> clamp to output range; otherwise wrap.
module fir_out_scale #(
  parameter int ACC_WIDTH = 29,
  parameter int SHIFT     = 12,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] dout
);

`ifdef FIR_MAC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = -MAXV - 1;

  logic signed [ACC_WIDTH-1:0] s;

  assign s = acc >>> SHIFT;

  always_comb begin
    dout = s[OUT_WIDTH-1:0];
    if (s > MAXV) begin
      dout = MAXV[OUT_WIDTH-1:0];
    end else if (s < MINV) begin
      dout = MINV[OUT_WIDTH-1:0];
    end
  end
`else
  assign dout = OUT_WIDTH'(acc >>> SHIFT);
`endif

endmodule

// File: rtl/fir_mac_u.sv
// fir_mac_u: time-shared MAC behind the FIR delay line, one product per cycle.
// Output narrowing set by FIR_MAC_SATURATE_EN (see fir_out_scale).
module fir_mac_u
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int COEF_WIDTH = COEF_WIDTH_D,
  parameter int TAPS       = TAPS_D,
  parameter int SHIFT      = SHIFT_D,
  parameter int OUT_WIDTH  = OUT_WIDTH_D
) (
  input logic        CLK,
  input logic        RST_n,
  fir_mac_u_if.slave bus
);

  localparam int AW        = $clog2(TAPS);
  localparam int PW        = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_WIDTH = PW + AW;

  fir_mac_state_t state, state_d;

  logic [AW-1:0]                idx;
  logic signed [DATA_WIDTH-1:0] snap  [TAPS];
  logic signed [COEF_WIDTH-1:0] coef  [TAPS];
  logic signed [COEF_WIDTH-1:0] csnap [TAPS];
  logic signed [ACC_WIDTH-1:0]  acc, acc_d;
  logic signed [PW-1:0]         prod;
  logic signed [OUT_WIDTH-1:0]  dout_q, dout_d;
  logic                         vout_q, busy_q, ovr_q;
  logic                         last;

  assign prod  = PW'(snap[idx]) * PW'(csnap[idx]);
  assign acc_d = acc + ACC_WIDTH'(prod);
  assign last  = (idx == AW'(TAPS - 1));

  fir_out_scale #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_scale (
    .acc  (acc_d),
    .dout (dout_d)
  );

  always_comb begin
    state_d = state;
    unique case (1'b1)
      (state == IDLE): if (bus.VIN) state_d = MAC;
      (state == MAC):  if (last) state_d = OUT;
      (state == OUT):  state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state  <= IDLE;
      idx    <= '0;
      acc    <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
      snap   <= '{default: '0};
      coef   <= '{default: '0};
      csnap  <= '{default: '0};
    end else begin
      state  <= state_d;
      busy_q <= (state_d != IDLE);
      vout_q <= (state_d == OUT);
      if (bus.VIN && busy_q) begin
        ovr_q <= 1'b1;
      end
      if (bus.COEF_WE && !busy_q) begin
        coef[bus.COEF_ADDR] <= bus.COEF_DIN;
      end
      // coefs are snapshotted so a same-cycle write only affects later samples
      if ((state == IDLE) && bus.VIN) begin
        snap  <= bus.tp;
        csnap <= coef;
        acc   <= '0;
        idx   <= '0;
      end
      if (state == MAC) begin
        acc <= acc_d;
        idx <= idx + 1'b1;
        if (last) begin
          dout_q <= dout_d;
        end
      end
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.VOUT = vout_q;
  assign bus.BUSY = busy_q;
  assign bus.OVR  = ovr_q;

endmodule
